mem_dump_reader: RTL and testbench

Sequential readout engine for the CPU's instruction/data RAM. On a start command it reads a contiguous address range through the RAM's synchronous read port and streams each word out over a valid/ready interface, tagged with its address and a last flag. It is the hardware read-back counterpart of program loading: the bench or a host link uses it to extract RAM contents after a run without hierarchical access into the memory array.

---
 rtl/mem_dump_reader.sv | 111 +++++++++++
 tb/tb_mem_dump_reader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
// Sequential RAM read-back engine: reads a contiguous address range through a
// synchronous read port and streams each word out over valid/ready with address and last tag.
module mem_dump_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  accept;
    logic                  zero_len;
    logic                  handshake;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        zero_len  = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        accept    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        zero_len  = 1'b1;
                    end
                end
            end
            FETCH:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = SEND;
            SEND: begin
                if (out_valid && out_ready) begin
                    handshake = 1'b1;
                    state_nxt = out_last ? IDLE : FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_rd_en = (state == FETCH);
    assign mem_addr  = cur_addr;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output word register is loaded in CAPTURE, when the RAM data from FETCH is valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= zero_len || (handshake && out_last);
            if (accept) begin
                cur_addr  <= base_addr;
                remaining <= length;
            end
            if (state == CAPTURE) begin
                out_data  <= mem_rdata;
                out_addr  <= cur_addr;
                out_last  <= (remaining == REM_ONE);
                out_valid <= 1'b1;
            end
            if (handshake) begin
                out_valid <= 1'b0;
                remaining <= remaining - REM_ONE;
                cur_addr  <= cur_addr + ADDR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: table of dump vectors plus random dumps, checked
// against a queue-based model of the expected word stream and hand-written reset sequences.
module tb_mem_dump_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  length;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [256];

    mem_dump_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // mode 0: ready always 1, mode 1: random ready, mode 2: ready pattern 1,0,0,1
    task automatic run_dump(input logic [7:0] b, input logic [8:0] n, input int mode,
                            input bit poke, output logic [7:0] fa, output logic [7:0] la);
        logic [24:0] exp_q[$];
        logic [24:0] got_q[$];
        logic [24:0] prev_word;
        logic [3:0]  pat;
        logic [7:0]  a;
        bit          finished, prev_valid, prev_ready, first_seen;
        int          cyc, budget, rd_cnt, stab_err, busy_err, tim_err;
        int          first_v, last_hs, done_idx;
        pat = 4'b1001;
        for (int i = 0; i < int'(n); i++) begin
            a = b + 8'(i);
            exp_q.push_back({(i == int'(n) - 1), a, mem[a]});
        end
        @(negedge clk);
        start = 1'b1; base_addr = b; length = n;
        @(negedge clk);
        start = 1'b0; base_addr = 8'($urandom); length = 9'($urandom);
        finished = 0; prev_valid = 0; prev_ready = 0; first_seen = 0;
        cyc = 0; budget = int'(n) * 8 + 20; rd_cnt = 0; stab_err = 0; busy_err = 0;
        tim_err = 0; first_v = -1; last_hs = -1; done_idx = -1; prev_word = '0;
        while (!finished && cyc < budget) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = pat[cyc % 4];
            endcase
            if (poke && cyc == 10) begin
                start = 1'b1; base_addr = 8'd77; length = 9'd5;
            end
            if (poke && cyc == 11) start = 1'b0;
            if (busy !== ((n != 0) && !done)) busy_err++;
            if (done) begin
                finished = 1;
                done_idx = cyc;
            end
            if (mem_rd_en) rd_cnt++;
            if (prev_valid && !prev_ready &&
                (!out_valid || {out_last, out_addr, out_data} !== prev_word)) stab_err++;
            if (out_valid && !first_seen) begin
                first_seen = 1;
                first_v = cyc;
            end
            if (out_valid && out_ready) begin
                if (mode == 0 && cyc != 2 + 3 * got_q.size()) tim_err++;
                got_q.push_back({out_last, out_addr, out_data});
                last_hs = cyc;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_word  = {out_last, out_addr, out_data};
            cyc++;
            if (!finished) @(negedge clk);
        end
        out_ready = 1'b0;
        chk("dump_terminates", 64'(finished), 64'd1);
        chk("word_count", 64'(got_q.size()), 64'(n));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
        chk("rd_en_pulses", 64'(rd_cnt), 64'(n));
        chk("stall_stable", 64'(stab_err), 64'd0);
        chk("busy_track", 64'(busy_err), 64'd0);
        chk("done_cycle", 64'(done_idx), (n == 0) ? 64'd0 : 64'(last_hs + 1));
        if (mode == 0 && n != 0) begin
            chk("first_valid_cycle", 64'(first_v), 64'd2);
            chk("one_word_per_3", 64'(tim_err), 64'd0);
        end
        if (n == 0) chk("no_valid_len0", 64'(first_seen), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        fa = (got_q.size() > 0) ? got_q[0][23:16] : 8'd0;
        la = (got_q.size() > 0) ? got_q[got_q.size()-1][23:16] : 8'd0;
    endtask

    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        int         mode;
        bit         poke;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] fa, la, rb;
        logic [8:0] rn;
        int         waited;
        bit         post_err;
        vecs[0] = '{8'd4,   9'd3,   0, 1'b0, 8'd4,   8'd6};
        vecs[1] = '{8'd4,   9'd3,   2, 1'b0, 8'd4,   8'd6};
        vecs[2] = '{8'd254, 9'd4,   0, 1'b0, 8'd254, 8'd1};
        vecs[3] = '{8'd0,   9'd0,   0, 1'b0, 8'd0,   8'd0};
        vecs[4] = '{8'd0,   9'd256, 0, 1'b1, 8'd0,   8'd255};
        vecs[5] = '{8'd100, 9'd20,  1, 1'b0, 8'd100, 8'd119};
        vecs[6] = '{8'd250, 9'd256, 1, 1'b1, 8'd250, 8'd249};
        vecs[7] = '{8'd200, 9'd1,   1, 1'b0, 8'd200, 8'd200};

        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
        rst = 1'b0; start = 1'b0; out_ready = 1'b0; base_addr = '0; length = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({mem_rd_en, mem_addr, out_valid, out_data, out_addr,
                                  out_last, busy, done}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_dump(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].poke, fa, la);
            if (vecs[i].len != 0) begin
                chk($sformatf("vec%0d_first_addr", i), 64'(fa), 64'(vecs[i].exp_first));
                chk($sformatf("vec%0d_last_addr", i), 64'(la), 64'(vecs[i].exp_last));
            end
        end

        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom);
            rn = 9'($urandom_range(1, 256));
            run_dump(rb, rn, 1, 1'b0, fa, la);
            chk("rand_first_addr", 64'(fa), 64'(rb));
            chk("rand_last_addr", 64'(la), 64'(8'(rb + 8'(rn - 9'd1))));
        end

        // Reset while word 2 of 5 is held in SEND
        @(negedge clk);
        start = 1'b1; base_addr = 8'd10; length = 9'd5;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!out_valid && waited < 20) begin @(negedge clk); waited++; end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        waited = 0;
        while (!out_valid && waited < 20) begin @(negedge clk); waited++; end
        chk("word2_presented", 64'({out_valid, out_addr}), 64'({1'b1, 8'd11}));
        rst = 1'b0;
        #1;
        chk("reset_mid_dump", 64'({mem_rd_en, mem_addr, out_valid, out_data, out_addr,
                                   out_last, busy, done}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        post_err = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid || done || busy || mem_rd_en) post_err = 1;
        end
        chk("quiet_after_reset", 64'(post_err), 64'd0);
        run_dump(8'd7, 9'd2, 0, 1'b0, fa, la);
        chk("post_reset_first", 64'(fa), 64'd7);
        chk("post_reset_last", 64'(la), 64'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
